// File: rtl/int_branch_recovery_arbiter_pkg.sv
// Shared types and helpers for the integer branch recovery arbiter.
// Pointer and target widths here size the latched request struct.
package int_branch_recovery_arbiter_pkg;

    localparam int IBRA_AL_PTR_W = 6;
    localparam int IBRA_PC_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RECOVER
    } IntBrArbState;

    typedef struct packed {
        logic [IBRA_AL_PTR_W-1:0] alPtr;
        logic [IBRA_PC_W-1:0]     target;
    } IntBrRecoveryReq;

    // Distance from the active-list head; wraps modulo the list depth.
    function automatic logic [IBRA_AL_PTR_W-1:0] alAge(
        input logic [IBRA_AL_PTR_W-1:0] ptr,
        input logic [IBRA_AL_PTR_W-1:0] head
    );
        return ptr - head;
    endfunction

endpackage

// File: rtl/int_branch_recovery_arbiter_age_picker.sv
// int_br_age_picker: combinational oldest-of-N selector by active-list age.
// Ties go to the lowest lane index.
module int_br_age_picker
    import int_branch_recovery_arbiter_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int AL_PTR_W  = IBRA_AL_PTR_W,
    parameter int PC_W      = IBRA_PC_W,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [AL_PTR_W-1:0]           head_i,
    input  logic [NUM_LANES-1:0]          valid_i,
    input  logic [NUM_LANES*AL_PTR_W-1:0] ptr_i,
    input  logic [NUM_LANES*PC_W-1:0]     target_i,
    output logic                          pick_valid_o,
    output logic [LANE_W-1:0]             pick_lane_o,
    output logic [AL_PTR_W-1:0]           pick_ptr_o,
    output logic [PC_W-1:0]               pick_target_o
);

    logic [AL_PTR_W-1:0] lane_age;
    logic [AL_PTR_W-1:0] best_age;

    always_comb begin
        pick_valid_o  = 1'b0;
        pick_lane_o   = '0;
        pick_ptr_o    = '0;
        pick_target_o = '0;
        best_age      = '0;
        lane_age      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_age = alAge(ptr_i[i*AL_PTR_W +: AL_PTR_W], head_i);
            if (valid_i[i] && (!pick_valid_o || lane_age < best_age)) begin
                pick_valid_o  = 1'b1;
                pick_lane_o   = LANE_W'(i);
                pick_ptr_o    = ptr_i[i*AL_PTR_W +: AL_PTR_W];
                pick_target_o = target_i[i*PC_W +: PC_W];
                best_age      = lane_age;
            end
        end
    end

endmodule

// File: rtl/int_branch_recovery_arbiter.sv
// Holds the oldest integer-lane mispredict and sequences recovery.
// INT_BR_RECOVERY_ARB_PERF_EN adds saturating mispredict/pre-empt counters.
module int_branch_recovery_arbiter
    import int_branch_recovery_arbiter_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int AL_PTR_W  = IBRA_AL_PTR_W,
    parameter int PC_W      = IBRA_PC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AL_PTR_W-1:0]           alHeadPtr,
    input  logic [NUM_LANES-1:0]          mispredValid,
    input  logic [NUM_LANES*AL_PTR_W-1:0] mispredAlPtr,
    input  logic [NUM_LANES*PC_W-1:0]     mispredTarget,
    input  logic                          recoveryAck,
    input  logic                          recoveryDone,
    output logic                          recoveryReq,
    output logic [AL_PTR_W-1:0]           recoveryAlPtr,
    output logic [PC_W-1:0]               recoveryTarget,
    output logic                          busy
`ifdef INT_BR_RECOVERY_ARB_PERF_EN
    ,
    output logic [31:0]                   perfMispredCount,
    output logic [31:0]                   perfPreemptCount
`endif
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    IntBrArbState    state_q, state_d;
    IntBrRecoveryReq req_q, req_d;
    logic            take;
    logic            preempt;

    logic                pickValid;
    logic [LANE_W-1:0]   pickLane;
    logic [AL_PTR_W-1:0] pickPtr;
    logic [PC_W-1:0]     pickTarget;

    int_br_age_picker #(
        .NUM_LANES (NUM_LANES),
        .AL_PTR_W  (AL_PTR_W),
        .PC_W      (PC_W)
    ) u_picker (
        .head_i        (alHeadPtr),
        .valid_i       (mispredValid),
        .ptr_i         (mispredAlPtr),
        .target_i      (mispredTarget),
        .pick_valid_o  (pickValid),
        .pick_lane_o   (pickLane),
        .pick_ptr_o    (pickPtr),
        .pick_target_o (pickTarget)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        take    = 1'b0;
        preempt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pickValid) begin
                    req_d   = '{alPtr: pickPtr, target: pickTarget};
                    state_d = PEND;
                    take    = 1'b1;
                end
            end
            PEND: begin
                if (recoveryAck) begin
                    state_d = RECOVER;
                end else if (pickValid &&
                    alAge(pickPtr, alHeadPtr) < alAge(req_q.alPtr, alHeadPtr)) begin
                    req_d   = '{alPtr: pickPtr, target: pickTarget};
                    preempt = 1'b1;
                end
            end
            RECOVER: begin
                if (recoveryDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        recoveryReq    = (state_q == PEND);
        busy           = (state_q != IDLE);
        recoveryAlPtr  = req_q.alPtr;
        recoveryTarget = req_q.target;
    end

    a_pick_lane_valid: assert property (
        @(posedge clk) disable iff (rst) pickValid |-> mispredValid[pickLane]
    );

`ifdef INT_BR_RECOVERY_ARB_PERF_EN
    logic [31:0] perfMispred_q;
    logic [31:0] perfPreempt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfMispred_q <= '0;
            perfPreempt_q <= '0;
        end else begin
            if (take && perfMispred_q != '1) perfMispred_q <= perfMispred_q + 32'd1;
            if (preempt && perfPreempt_q != '1) perfPreempt_q <= perfPreempt_q + 32'd1;
        end
    end

    assign perfMispredCount = perfMispred_q;
    assign perfPreemptCount = perfPreempt_q;
`else
    logic unusedPerf;
    assign unusedPerf = take ^ preempt;
`endif

endmodule

// File: tb/tb_int_branch_recovery_arbiter.sv
// Scoreboard bench for int_branch_recovery_arbiter: directed scenarios
// followed by randomized traffic checked against a behavioural model.
module tb_int_branch_recovery_arbiter;

    localparam int NL = 2;
    localparam int AW = 6;
    localparam int PW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]    head;
    logic [NL-1:0]    mv;
    logic [NL*AW-1:0] mp;
    logic [NL*PW-1:0] mt;
    logic           ack;
    logic           done;
    logic           req;
    logic [AW-1:0]  rptr;
    logic [PW-1:0]  rtgt;
    logic           busy;
`ifdef INT_BR_RECOVERY_ARB_PERF_EN
    logic [31:0]    perfM;
    logic [31:0]    perfP;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic        busy;
        logic [5:0]  ptr;
        logic [31:0] tgt;
        logic [31:0] mc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    int_branch_recovery_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .alHeadPtr      (head),
        .mispredValid   (mv),
        .mispredAlPtr   (mp),
        .mispredTarget  (mt),
        .recoveryAck    (ack),
        .recoveryDone   (done),
        .recoveryReq    (req),
        .recoveryAlPtr  (rptr),
        .recoveryTarget (rtgt),
        .busy           (busy)
`ifdef INT_BR_RECOVERY_ARB_PERF_EN
        ,
        .perfMispredCount (perfM),
        .perfPreemptCount (perfP)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age from head by plain modulo arithmetic.
    function automatic int age(input int p, input int h);
        return (p - h + 64) % 64;
    endfunction

    int          mode;   // 0 nothing held, 1 request outstanding, 2 recovering
    logic [5:0]  mptr;
    logic [31:0] mtgt;
    logic [31:0] mcnt;
    logic [31:0] pcnt;

    task automatic oldest(output bit found, output int p, output logic [31:0] t);
        int best;
        found = 0;
        best  = 64;
        p     = 0;
        t     = '0;
        for (int i = 0; i < NL; i++) begin
            if (mv[i] && age(int'(mp[i*AW +: AW]), int'(head)) < best) begin
                best  = age(int'(mp[i*AW +: AW]), int'(head));
                found = 1;
                p     = int'(mp[i*AW +: AW]);
                t     = mt[i*PW +: PW];
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.req  = (mode == 1);
        e.busy = (mode != 0);
        e.ptr  = mptr;
        e.tgt  = mtgt;
        e.mc   = mcnt;
        e.pc   = pcnt;
        sb.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        bit          f;
        int          p;
        logic [31:0] t;
        if (rst) begin
            mode = 0;
            mptr = '0;
            mtgt = '0;
            mcnt = '0;
            pcnt = '0;
            sb.delete();
            push_exp();
        end else begin
            oldest(f, p, t);
            if (mode == 0) begin
                if (f) begin
                    mode = 1;
                    mptr = p[5:0];
                    mtgt = t;
                    mcnt = mcnt + 1;
                end
            end else if (mode == 1) begin
                if (ack) begin
                    mode = 2;
                end else if (f && age(p, int'(head)) < age(int'(mptr), int'(head))) begin
                    mptr = p[5:0];
                    mtgt = t;
                    pcnt = pcnt + 1;
                end
            end else if (done) begin
                mode = 0;
            end
            push_exp();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=0 required=1 t=%0t", $time);
        end else begin
            e = sb.pop_front();
            chk("sb_req", 32'(req), 32'(e.req));
            chk("sb_busy", 32'(busy), 32'(e.busy));
            chk("sb_ptr", 32'(rptr), 32'(e.ptr));
            chk("sb_tgt", rtgt, e.tgt);
`ifdef INT_BR_RECOVERY_ARB_PERF_EN
            chk("sb_perf_mispred", perfM, e.mc);
            chk("sb_perf_preempt", perfP, e.pc);
`endif
        end
    end

    task automatic clr();
        mv   = '0;
        ack  = 1'b0;
        done = 1'b0;
    endtask

    task automatic rep(input int l, input int p, input logic [31:0] t);
        mv[l]            = 1'b1;
        mp[l*AW +: AW]   = p[5:0];
        mt[l*PW +: PW]   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic finish_recovery();
        clr();
        ack = 1'b1;
        tick();
        clr();
        done = 1'b1;
        tick();
        clr();
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("async_req", 32'(req), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
`ifdef INT_BR_RECOVERY_ARB_PERF_EN
        chk("async_perf_mispred", perfM, 32'd0);
        chk("async_perf_preempt", perfP, 32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        clr();
        head = '0;
        mp   = '0;
        mt   = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ptr", 32'(rptr), 32'd0);
        chk("rst_tgt", rtgt, 32'd0);

        // single report
        rep(0, 5, 32'h1000);
        tick();
        clr();
        chk("single_req", 32'(req), 32'd1);
        chk("single_ptr", 32'(rptr), 32'd5);
        chk("single_tgt", rtgt, 32'h1000);
        ack = 1'b1;
        tick();
        clr();
        chk("ack_req", 32'(req), 32'd0);
        chk("ack_busy", 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        clr();
        chk("done_busy", 32'(busy), 32'd0);

        // simultaneous lanes, then tie
        rep(0, 9, 32'hA000);
        rep(1, 4, 32'hB000);
        tick();
        clr();
        chk("simul_ptr", 32'(rptr), 32'd4);
        chk("simul_tgt", rtgt, 32'hB000);
        finish_recovery();
        rep(0, 7, 32'hC000);
        rep(1, 7, 32'hD000);
        tick();
        clr();
        chk("tie_tgt", rtgt, 32'hC000);
        finish_recovery();

        // pre-emption
        head = 6'd10;
        rep(0, 20, 32'hE000);
        tick();
        clr();
        rep(1, 12, 32'hF000);
        tick();
        clr();
        chk("preempt_req", 32'(req), 32'd1);
        chk("preempt_ptr", 32'(rptr), 32'd12);
        chk("preempt_tgt", rtgt, 32'hF000);
        rep(0, 30, 32'h1234);
        tick();
        clr();
        chk("younger_drop_ptr", 32'(rptr), 32'd12);
        finish_recovery();

        // wrap-around
        head = 6'd60;
        rep(0, 62, 32'h6200);
        tick();
        clr();
        rep(0, 1, 32'h0100);
        tick();
        clr();
        chk("wrap_drop_ptr", 32'(rptr), 32'd62);
        rep(1, 61, 32'h6100);
        tick();
        clr();
        chk("wrap_preempt_ptr", 32'(rptr), 32'd61);
        chk("wrap_preempt_tgt", rtgt, 32'h6100);
        finish_recovery();

        // RECOVER isolation
        head = 6'd0;
        rep(0, 5, 32'h5000);
        tick();
        clr();
        ack = 1'b1;
        tick();
        clr();
        repeat (3) begin
            rep(0, 3, 32'h3000);
            tick();
            chk("recover_no_req", 32'(req), 32'd0);
            chk("recover_ptr_hold", 32'(rptr), 32'd5);
        end
        done = 1'b1;
        rep(0, 3, 32'h3000);
        tick();
        clr();
        chk("done_cycle_busy", 32'(busy), 32'd0);
        tick();
        chk("done_drop_busy", 32'(busy), 32'd0);
        chk("done_drop_req", 32'(req), 32'd0);

        // async reset mid-PEND
        rep(0, 8, 32'h8000);
        tick();
        clr();
        async_reset();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            clr();
            head = head + 6'($urandom_range(0, 1));
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(0, 2) == 0)
                    rep(l, int'($urandom_range(0, 63)), $urandom);
            end
            ack  = ($urandom_range(0, 3) == 0);
            done = ($urandom_range(0, 3) == 0);
            tick();
            if (n % 400 == 399) async_reset();
        end

        clr();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
